// File: rtl/conv_tap_chain.sv
// Transposed-form 1-D convolution tap chain: weights are loaded by handshake, then one full-window sum is produced per accepted sample.
// Optional build macro CONV_CHAIN_RELU_EN clamps negative results to zero in the output register.
module conv_tap_chain #(
  parameter int TAPS = 25,
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int AW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_start,
  input  logic                 w_valid,
  input  logic signed [WW-1:0] w_in,
  output logic                 w_ready,
  output logic                 loaded,
  input  logic                 clr,
  input  logic                 d_valid,
  input  logic signed [DW-1:0] d_in,
  output logic                 d_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_data,
  output logic [1:0]           dbg_state
);

  // Handshakes: a word moves on any rising edge where valid and ready are both high;
  // ready never depends on the matching valid, and w_start overrides every transfer.

  localparam int PW = DW + WW;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic signed [WW-1:0]  w_q [TAPS];
  logic signed [WW-1:0]  w_d [TAPS];
  logic signed [AW-1:0]  s_q [1:TAPS-1];
  logic signed [AW-1:0]  s_d [1:TAPS-1];
  logic signed [AW-1:0]  s_nxt [1:TAPS-1];
  logic signed [AW-1:0]  prod [TAPS];
  logic signed [AW-1:0]  y, y_out;
  logic                  ov_q, ov_d;
  logic signed [AW-1:0]  od_q, od_d;
  logic                  accept;

  assign w_ready   = (state_q == S_LOAD);
  assign loaded    = (state_q == S_RUN);
  assign d_ready   = (state_q == S_RUN) & ~clr & (~ov_q | out_ready);
  assign accept    = d_valid & d_ready & ~w_start;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign dbg_state = state_q;

  // The incoming sample is broadcast to every tap; each partial absorbs its product plus its upstream neighbour.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = AW'(PW'(w_q[k]) * PW'(d_in));
    end
    for (int k = 1; k < TAPS - 1; k++) begin
      s_nxt[k] = prod[k] + s_q[k+1];
    end
    s_nxt[TAPS-1] = prod[TAPS-1];
    y = prod[0] + s_q[1];
`ifdef CONV_CHAIN_RELU_EN
    y_out = y[AW-1] ? '0 : y;
`else
    y_out = y;
`endif
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fill_d  = fill_q;
    w_d     = w_q;
    s_d     = s_q;
    ov_d    = ov_q;
    od_d    = od_q;
    if (w_start) begin
      state_d = S_LOAD;
      wcnt_d  = '0;
      fill_d  = '0;
      ov_d    = 1'b0;
      for (int k = 0; k < TAPS; k++) w_d[k] = '0;
      for (int k = 1; k < TAPS; k++) s_d[k] = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (w_valid) begin
            w_d[wcnt_q] = w_in;
            if (wcnt_q == LAST) begin
              state_d = S_RUN;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (clr) begin
            fill_d = '0;
            ov_d   = 1'b0;
            for (int k = 1; k < TAPS; k++) s_d[k] = '0;
          end else begin
            if (out_ready) ov_d = 1'b0;
            if (accept) begin
              s_d = s_nxt;
              if (fill_q == LAST) begin
                ov_d = 1'b1;
                od_d = y_out;
              end else begin
                fill_d = fill_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      fill_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      for (int k = 0; k < TAPS; k++) w_q[k] <= '0;
      for (int k = 1; k < TAPS; k++) s_q[k] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fill_q  <= fill_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      w_q     <= w_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_conv_tap_chain.sv
// Directed bench for conv_tap_chain: reset, window sums, impulse response, extremes, backpressure, clear, mid-run reset.
module tb_conv_tap_chain;

  localparam int TAPS = 25;

  logic               clk = 1'b0;
  logic               rst;
  logic               w_start, w_valid, clr, d_valid, out_ready;
  logic signed [7:0]  w_in, d_in;
  logic               w_ready, loaded, d_ready, out_valid;
  logic signed [31:0] out_data;
  logic [1:0]         dbg_state;

  int errors = 0;
  int checks = 0;

  logic signed [7:0]  wt [TAPS];
  logic signed [7:0]  hist [$];

  conv_tap_chain #(.TAPS(TAPS), .DW(8), .WW(8), .AW(32)) dut (
    .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_in(w_in),
    .w_ready(w_ready), .loaded(loaded), .clr(clr), .d_valid(d_valid), .d_in(d_in),
    .d_ready(d_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] clampv(input logic signed [31:0] v);
`ifdef CONV_CHAIN_RELU_EN
    return (v < 0) ? 32'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Direct-form reference over the accepted-sample history since the last load/clear.
  function automatic logic signed [31:0] model_y();
    longint acc;
    int n;
    acc = 0;
    n = hist.size() - 1;
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0) acc += longint'(wt[k]) * longint'(hist[n-k]);
    return clampv(acc[31:0]);
  endfunction

  task automatic load_weights();
    @(negedge clk);
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    checks++;
    if (w_ready !== 1'b1) begin
      errors++; $display("FAIL load_w_ready: got %b want 1", w_ready);
    end
    for (int k = 0; k < TAPS; k++) begin
      w_valid = 1'b1;
      w_in = wt[k];
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    checks++;
    if (loaded !== 1'b1 || w_ready !== 1'b0) begin
      errors++; $display("FAIL load_done: loaded=%b w_ready=%b want 1/0", loaded, w_ready);
    end
    hist.delete();
    @(negedge clk);
  endtask

  task automatic send_sample(input logic signed [7:0] x, output logic gv, output logic signed [31:0] gd);
    int n;
    d_valid = 1'b1;
    d_in = x;
    #1;
    n = 0;
    while (d_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: d_ready stuck at %b want 1", d_ready);
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
    hist.push_back(x);
    @(negedge clk);
    gv = out_valid;
    gd = out_data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (w_ready !== 1'b0 || loaded !== 1'b0 || d_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 32'sd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: w_ready=%b loaded=%b d_ready=%b out_valid=%b out_data=%0d state=%0d want all 0",
               w_ready, loaded, d_ready, out_valid, out_data, dbg_state);
    end
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    logic gv;
    logic signed [31:0] gd;
    for (int k = 0; k < TAPS; k++) wt[k] = 8'sd1;
    load_weights();
    for (int n = 0; n < 26; n++) begin
      send_sample(8'(n + 1), gv, gd);
      checks++;
      if (n < 24) begin
        if (gv !== 1'b0) begin errors++; $display("FAIL ramp_silent n=%0d: out_valid=%b want 0", n, gv); end
      end else begin
        if (gv !== 1'b1 || gd !== clampv(n == 24 ? 32'sd325 : 32'sd350)) begin
          errors++; $display("FAIL ramp_sum n=%0d: valid=%b data=%0d want 1/%0d", n, gv, gd, (n == 24) ? 325 : 350);
        end
      end
    end
  endtask

  task automatic test_impulse();
    logic gv;
    logic signed [31:0] gd;
    logic signed [31:0] want;
    for (int k = 0; k < TAPS; k++) wt[k] = 8'(k + 1);
    load_weights();
    for (int n = 0; n < 50; n++) begin
      send_sample((n == 24) ? 8'sd1 : 8'sd0, gv, gd);
      if (n >= 24) begin
        want = (n < 49) ? 32'(n - 23) : 32'sd0;
        checks++;
        if (gv !== 1'b1 || gd !== want) begin
          errors++; $display("FAIL impulse n=%0d: valid=%b data=%0d want 1/%0d", n, gv, gd, want);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic gv;
    logic signed [31:0] gd;
    for (int k = 0; k < TAPS; k++) wt[k] = -8'sd128;
    load_weights();
    for (int n = 0; n < TAPS; n++) send_sample(-8'sd128, gv, gd);
    checks++;
    if (gv !== 1'b1 || gd !== clampv(32'sd409600)) begin
      errors++; $display("FAIL extreme_pos: valid=%b data=%0d want 1/409600", gv, gd);
    end
    for (int n = 0; n < TAPS; n++) send_sample(8'sd127, gv, gd);
    checks++;
    if (gv !== 1'b1 || gd !== clampv(-32'sd406400)) begin
      errors++; $display("FAIL extreme_neg: valid=%b data=%0d want 1/%0d", gv, gd, clampv(-32'sd406400));
    end
  endtask

  task automatic test_backpressure();
    logic gv;
    logic signed [31:0] gd;
    logic signed [31:0] held;
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0;
    send_sample(8'sd5, gv, gd);
    checks++;
    if (gv !== 1'b1 || gd !== model_y()) begin
      errors++; $display("FAIL bp_first: valid=%b data=%0d want 1/%0d", gv, gd, model_y());
    end
    held = gd;
    d_valid = 1'b1;
    d_in = 8'sd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (d_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        errors++; $display("FAIL bp_hold cyc=%0d: d_ready=%b valid=%b data=%0d want 0/1/%0d",
                           i, d_ready, out_valid, out_data, held);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: d_ready=%b want 1", d_ready);
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
    hist.push_back(8'sd6);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== model_y()) begin
      errors++; $display("FAIL bp_after: valid=%b data=%0d want 1/%0d", out_valid, out_data, model_y());
    end
  endtask

  task automatic test_clear();
    logic gv;
    logic signed [31:0] gd;
    for (int k = 0; k < TAPS; k++) wt[k] = 8'((k % 5) - 2);
    load_weights();
    for (int n = 0; n < 30; n++) send_sample(8'((n * 7) % 19 - 9), gv, gd);
    checks++;
    if (gv !== 1'b1 || gd !== model_y()) begin
      errors++; $display("FAIL clr_pre: valid=%b data=%0d want 1/%0d", gv, gd, model_y());
    end
    clr = 1'b1;
    d_valid = 1'b1;
    d_in = 8'sd3;
    #1;
    checks++;
    if (d_ready !== 1'b0) begin
      errors++; $display("FAIL clr_ready: d_ready=%b want 0", d_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    d_valid = 1'b0;
    hist.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || loaded !== 1'b1) begin
      errors++; $display("FAIL clr_state: valid=%b loaded=%b want 0/1", out_valid, loaded);
    end
    for (int n = 0; n < TAPS; n++) begin
      send_sample(8'(n * 3 - 30), gv, gd);
      checks++;
      if (n < TAPS - 1) begin
        if (gv !== 1'b0) begin errors++; $display("FAIL clr_silent n=%0d: out_valid=%b want 0", n, gv); end
      end else if (gv !== 1'b1 || gd !== model_y()) begin
        errors++; $display("FAIL clr_fresh: valid=%b data=%0d want 1/%0d", gv, gd, model_y());
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    d_valid = 1'b1;
    d_in = 8'sd9;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (w_ready !== 1'b0 || loaded !== 1'b0 || d_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 32'sd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midrun_reset: w_ready=%b loaded=%b d_ready=%b out_valid=%b out_data=%0d want all 0",
               w_ready, loaded, d_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (d_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL midrun_ignore cyc=%0d: d_ready=%b out_valid=%b want 0/0", i, d_ready, out_valid);
      end
    end
    d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    w_start = 1'b0; w_valid = 1'b0; w_in = '0;
    clr = 1'b0; d_valid = 1'b0; d_in = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_ramp();
    test_impulse();
    test_extremes();
    test_backpressure();
    test_clear();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
